// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state type, opcodes and index-width helper for the serial adder/subtractor
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } addsub_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational D-bit ripple slice shared by the add/subtract and negate passes
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int D = 2
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         inv_b,
    input  logic         cin,
    output logic [D-1:0] s,
    output logic         cout
);

    logic [D:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {D{inv_b}}} + {{D{1'b0}}, cin};
    assign s    = sum[D-1:0];
    assign cout = sum[D];

endmodule

// File: rtl/addsub_serial_nbit.sv
// rtl/addsub_serial_nbit.sv - digit-serial N-bit add/subtract with start/done; ADDSUB_ABS_EN adds magnitude correction
module addsub_serial_nbit
    import addsub_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] result,
    output logic         neg,
    output logic         cout,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    localparam int              K    = N / D;
    localparam int              IW   = idx_width(K);
    localparam logic [IW-1:0]   LAST = IW'(K - 1);

    generate
        if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
            $error("addsub_serial_nbit: N must be >= 2 and a multiple of D");
        end
    endgenerate

    addsub_state_t state, state_nxt;
    logic [N-1:0]  a_r, b_r, result_nxt;
    logic          op_r, carry;
    logic [IW-1:0] idx;
    logic [D-1:0]  cur_a, cur_b, cur_r, dig_a, dig_b, dig_s;
    logic          dig_inv, dig_cout;

    assign cur_a = a_r[idx*D +: D];
    assign cur_b = b_r[idx*D +: D];
    assign cur_r = result[idx*D +: D];
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    // One slice serves both passes: CALC feeds operands, NEG feeds ~digit with carry-in 1.
    always_comb begin
        dig_a   = cur_a;
        dig_b   = cur_b;
        dig_inv = op_r;
`ifdef ADDSUB_ABS_EN
        if (state == NEG) begin
            dig_a   = ~cur_r;
            dig_b   = '0;
            dig_inv = 1'b0;
        end
`endif
    end

    addsub_digit #(.D(D)) u_digit (
        .a     (dig_a),
        .b     (dig_b),
        .inv_b (dig_inv),
        .cin   (carry),
        .s     (dig_s),
        .cout  (dig_cout)
    );

    always_comb begin
        result_nxt             = result;
        result_nxt[idx*D +: D] = dig_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (idx == LAST) begin
`ifdef ADDSUB_ABS_EN
                state_nxt = (op_r == OP_SUB && !dig_cout) ? NEG : DONE;
`else
                state_nxt = DONE;
`endif
            end
`ifdef ADDSUB_ABS_EN
            NEG:  if (idx == LAST) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            neg    <= 1'b0;
            cout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r    <= A;
                    b_r    <= B;
                    op_r   <= op;
                    carry  <= op;
                    idx    <= '0;
                    result <= '0;
                    neg    <= 1'b0;
                    cout   <= 1'b0;
                    zero   <= 1'b0;
                end
                CALC: begin
                    result <= result_nxt;
                    carry  <= dig_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx  <= '0;
                        cout <= dig_cout;
                        neg  <= (op_r == OP_SUB) & ~dig_cout;
`ifdef ADDSUB_ABS_EN
                        if (op_r == OP_SUB && !dig_cout) carry <= 1'b1;
                        else                             zero  <= (result_nxt == '0);
`else
                        zero <= (result_nxt == '0);
`endif
                    end
                end
`ifdef ADDSUB_ABS_EN
                NEG: begin
                    result <= result_nxt;
                    carry  <= dig_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx  <= '0;
                        zero <= (result_nxt == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// tb/tb_addsub_serial_nbit.sv - scoreboard bench for addsub_serial_nbit at D=2, D=1 and D=8 (N=8)
module tb_addsub_serial_nbit;

`ifdef ADDSUB_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    typedef struct {
        int res;
        int neg;
        int cout;
        int zero;
        int units;
        int acc;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       op_in = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;

    logic [7:0] res_w  [3];
    logic       neg_w  [3];
    logic       cout_w [3];
    logic       zero_w [3];
    logic       busy_w [3];
    logic       done_w [3];

    int     cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    entry_t entries [512];
    int     wr_ptr = 0;
    int     rd_ptr [3] = '{0, 0, 0};
    entry_t last [3];
    bit     have_last [3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_serial_nbit #(.N(8), .D(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .A(a_in), .B(b_in),
        .result(res_w[0]), .neg(neg_w[0]), .cout(cout_w[0]), .zero(zero_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );
    addsub_serial_nbit #(.N(8), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .A(a_in), .B(b_in),
        .result(res_w[1]), .neg(neg_w[1]), .cout(cout_w[1]), .zero(zero_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );
    addsub_serial_nbit #(.N(8), .D(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op_in), .A(a_in), .B(b_in),
        .result(res_w[2]), .neg(neg_w[2]), .cout(cout_w[2]), .zero(zero_w[2]),
        .busy(busy_w[2]), .done(done_w[2])
    );

    function automatic int k_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 1;
    endfunction

    function automatic entry_t model(input int a, input int b, input bit o, input int acc);
        entry_t e;
        e.acc = acc;
        e.units = 1;
        if (!o) begin
            e.res  = (a + b) % 256;
            e.cout = (a + b > 255) ? 1 : 0;
            e.neg  = 0;
        end else begin
            e.cout = (a >= b) ? 1 : 0;
            e.neg  = (a < b) ? 1 : 0;
            if (ABS && a < b) begin
                e.res   = b - a;
                e.units = 2;
            end else begin
                e.res = (a - b + 256) % 256;
            end
        end
        e.zero = (e.res == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", nm, inst, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                rd_ptr[i]    = wr_ptr;
                have_last[i] = 1'b0;
                chk("reset_result", i, int'(res_w[i]), 0);
                chk("reset_flags", i, int'({neg_w[i], cout_w[i], zero_w[i]}), 0);
                chk("reset_busy_done", i, int'({busy_w[i], done_w[i]}), 0);
            end else if (done_w[i]) begin
                if (rd_ptr[i] == wr_ptr) begin
                    chk("unexpected_done", i, 1, 0);
                end else begin
                    entry_t e;
                    e = entries[rd_ptr[i]];
                    rd_ptr[i]++;
                    chk("result", i, int'(res_w[i]), e.res);
                    chk("neg", i, int'(neg_w[i]), e.neg);
                    chk("cout", i, int'(cout_w[i]), e.cout);
                    chk("zero", i, int'(zero_w[i]), e.zero);
                    chk("latency", i, cyc - e.acc, e.units * k_of(i));
                    chk("busy_in_done", i, int'(busy_w[i]), 1);
                    last[i]      = e;
                    have_last[i] = 1'b1;
                end
            end else begin
                if (rd_ptr[i] != wr_ptr &&
                    cyc > entries[rd_ptr[i]].acc + entries[rd_ptr[i]].units * k_of(i) + 4) begin
                    chk("done_timeout", i, 0, 1);
                    rd_ptr[i]++;
                end
                if (!busy_w[i] && have_last[i]) begin
                    chk("hold_result", i, int'(res_w[i]), last[i].res);
                    chk("hold_flags", i, int'({neg_w[i], cout_w[i], zero_w[i]}),
                        int'({last[i].neg[0], last[i].cout[0], last[i].zero[0]}));
                end
            end
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (rd_ptr[0] == wr_ptr && rd_ptr[1] == wr_ptr && rd_ptr[2] == wr_ptr) break;
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit o);
        wait_idle();
        @(negedge clk);
        #1;
        a_in  = a;
        b_in  = b;
        op_in = o;
        start = 1'b1;
        entries[wr_ptr] = model(int'(a), int'(b), o, cyc + 1);
        wr_ptr++;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        op_in = 1'($urandom);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        issue(8'd200, 8'd100, 1'b0);
        issue(8'd50, 8'd20, 1'b1);
        issue(8'd20, 8'd50, 1'b1);
        issue(8'd77, 8'd77, 1'b1);
        issue(8'd255, 8'd1, 1'b0);

        issue(8'd20, 8'd50, 1'b1);
        @(negedge clk);
        #1;
        a_in  = 8'd3;
        b_in  = 8'd99;
        op_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        issue(8'd123, 8'd45, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        issue(8'd9, 8'd4, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (n % 8 == 0) ? ra : 8'($urandom);
            issue(ra, rb, 1'($urandom));
        end
        issue(8'd0, 8'd255, 1'b1);
        issue(8'd255, 8'd255, 1'b0);
        issue(8'd0, 8'd0, 1'b0);

        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
